jtframe_sdram_arb: RTL

JTFRAME_SDRAM_ARB -- requirements
Module: jtframe_sdram_arb

---
 rtl/jtframe_sdram_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: arbitrates CH requesting channels onto a single SDRAM
// bank port. Fixed-priority or round-robin selection, a GRANT/WAIT
// handshake with the bank, and a saturating timeout that aborts a stuck
// transaction and raises a sticky error flag.
module jtframe_sdram_arb #(
    parameter int AW    = 22,
    parameter int CH    = 2,
    parameter int RR    = 0,
    parameter int TOUTW = 8
) (
    input  logic [0:0]       clk,
    input  logic [0:0]       rst,
    // channel side
    input  logic [CH*AW-1:0] req_addr,
    input  logic [CH-1:0]    req_rd,
    input  logic [CH-1:0]    req_wr,
    input  logic [CH*16-1:0] req_din,
    input  logic [CH*2-1:0]  req_din_m,
    output logic [CH-1:0]    req_ack,
    output logic [CH-1:0]    req_dst,
    output logic [CH-1:0]    req_rdy,
    // SDRAM bank side
    output logic [AW-1:0]    ba_addr,
    output logic [0:0]       ba_rd,
    output logic [0:0]       ba_wr,
    output logic [15:0]      ba_din,
    output logic [1:0]       ba_din_m,
    input  logic [0:0]       ba_ack,
    input  logic [0:0]       ba_dst,
    input  logic [0:0]       ba_rdy,
    // status
    output logic [2:0]       owner,
    output logic [0:0]       busy,
    output logic [0:0]       timeout,
    output logic [0:0]       err,
    input  logic [0:0]       err_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       last_q,  last_d;
    logic [TOUTW-1:0] cnt_q,   cnt_d;
    logic             err_q,   err_d;
    logic             tout_q,  tout_d;
    logic             hold_q,  hold_d;

    logic [CH-1:0]    pend;
    logic             any_pend;
    logic [2:0]       win;
    logic [2:0]       lo_win, hi_win;
    logic             lo_found, hi_found;

    logic [AW-1:0]    own_addr;
    logic             own_rd, own_wr;
    logic [15:0]      own_din;
    logic [1:0]       own_din_m;

    logic             in_grant;
    logic             cnt_full;
    logic             abort;

    assign in_grant = (state_q == GRANT);
    assign cnt_full = &cnt_q;
    assign pend     = req_rd | req_wr;
    assign any_pend = |pend;

    // Select the owner channel's address, data, mask and request levels.
    always_comb begin
        own_addr  = '0;
        own_rd    = 1'b0;
        own_wr    = 1'b0;
        own_din   = '0;
        own_din_m = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (owner_q == 3'(i)) begin
                own_addr  = req_addr[i*AW +: AW];
                own_rd    = req_rd[i];
                own_wr    = req_wr[i];
                own_din   = req_din[i*16 +: 16];
                own_din_m = req_din_m[i*2 +: 2];
            end
        end
    end

    // Pick the winner: lowest pending index, or in round-robin mode the
    // first pending index above the last owner, wrapping to the lowest.
    always_comb begin
        lo_win   = '0;
        hi_win   = '0;
        lo_found = 1'b0;
        hi_found = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (pend[i] && !lo_found) begin
                lo_win   = 3'(i);
                lo_found = 1'b1;
            end
            if (pend[i] && !hi_found && (3'(i) > last_q)) begin
                hi_win   = 3'(i);
                hi_found = 1'b1;
            end
        end
        win = ((RR != 0) && hi_found) ? hi_win : lo_win;
    end

    // Next-state logic: arbitration, bank handshake, withdrawal and timeout.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tout_d  = 1'b0;
        hold_d  = 1'b0;
        abort   = 1'b0;

        if (state_q != IDLE && !cnt_full) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!hold_q && any_pend) begin
                    state_d = GRANT;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (cnt_full && !ba_rdy) begin
                    abort = 1'b1;
                end else if (ba_ack) begin
                    state_d = ba_rdy ? IDLE : WAIT;
                end else if (!own_rd && !own_wr) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (ba_rdy) begin
                    state_d = IDLE;
                end else if (cnt_full) begin
                    abort = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            tout_d  = 1'b1;
        end

        // One settle cycle after every return to IDLE keeps grant-to-grant
        // spacing at three cycles even when ack and rdy arrive together.
        if (state_q != IDLE && state_d == IDLE) begin
            hold_d = 1'b1;
        end

        if (abort) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State register with synchronous reset; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= 3'(CH-1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
            hold_q  <= hold_d;
        end
    end

    // Route bank handshake returns to the owner channel only.
    always_comb begin
        req_ack = '0;
        req_dst = '0;
        req_rdy = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (owner_q == 3'(i)) begin
                req_ack[i] = ba_ack & in_grant;
                req_dst[i] = ba_dst & busy;
                req_rdy[i] = ba_rdy & busy;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign ba_addr  = own_addr;
    assign ba_din   = own_din;
    assign ba_din_m = own_din_m;
    assign ba_wr    = own_wr & in_grant;
    assign ba_rd    = own_rd & in_grant & ~own_wr;
    assign owner    = owner_q;
    assign timeout  = tout_q;
    assign err      = err_q;

endmodule
